// File: rtl/mem_write_checker.sv
// In-order checker for CPU store traffic against a programmable table of expected stores.
// Reports pass/fail with error code, progress counters and the offending store.
module mem_write_checker #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned TIMEOUT    = 500,
  parameter bit          STRICT     = 1'b0,
  localparam int unsigned IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [IDX_W:0]    hits,
  output logic [31:0]       cycles,
  output logic [ADDR_W-1:0] bad_adr,
  output logic [DATA_W-1:0] bad_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_DATA    = 2'd1;
  localparam logic [1:0] E_ADDR    = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  localparam logic [IDX_W:0] HITS_ALL = (IDX_W+1)'(NUM_CHECKS);
  localparam logic [31:0]    CYC_LAST = 32'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W:0]    hits_q, hits_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] bad_adr_q, bad_adr_d;
  logic [DATA_W-1:0] bad_data_q, bad_data_d;
  logic              busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic [ADDR_W-1:0] tab_addr_q [NUM_CHECKS];
  logic [ADDR_W-1:0] tab_addr_d [NUM_CHECKS];
  logic [DATA_W-1:0] tab_data_q [NUM_CHECKS];
  logic [DATA_W-1:0] tab_data_d [NUM_CHECKS];

  logic [IDX_W-1:0]  cur_idx_c;
  logic [IDX_W:0]    hits_inc_c;
  logic              addr_hit_c, data_hit_c, idx_ok_c, decided_c;

  assign cur_idx_c  = hits_q[IDX_W-1:0];
  assign hits_inc_c = hits_q + (IDX_W+1)'(1);
  assign addr_hit_c = (data_adr == tab_addr_q[cur_idx_c]);
  assign data_hit_c = (write_data == tab_data_q[cur_idx_c]);
  assign idx_ok_c   = ({1'b0, exp_idx} < HITS_ALL);

  // Next-state, table update and diagnostics
  always_comb begin
    state_d    = state_q;
    hits_d     = hits_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    bad_adr_d  = bad_adr_q;
    bad_data_d = bad_data_q;
    tab_addr_d = tab_addr_q;
    tab_data_d = tab_data_q;
    decided_c  = 1'b0;

    // Table is frozen while a check runs so the run sees a stable expectation
    if (exp_we && (state_q != S_RUN) && idx_ok_c) begin
      tab_addr_d[exp_idx] = exp_addr;
      tab_data_d[exp_idx] = exp_data;
    end

    case (state_q)
      S_RUN: begin
        if (mem_write) begin
          if (addr_hit_c && data_hit_c) begin
            hits_d = hits_inc_c;
            if (hits_inc_c == HITS_ALL) begin
              state_d   = S_PASS;
              decided_c = 1'b1;
            end
          end else if (addr_hit_c || STRICT) begin
            state_d    = S_FAIL;
            err_d      = addr_hit_c ? E_DATA : E_ADDR;
            bad_adr_d  = data_adr;
            bad_data_d = write_data;
            decided_c  = 1'b1;
          end
        end
        // A deciding store on the same edge takes priority over the timeout
        if (!decided_c) begin
          if (cycles_q >= CYC_LAST) begin
            state_d = S_FAIL;
            err_d   = E_TIMEOUT;
          end else begin
            cycles_d = cycles_q + 32'd1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = S_RUN;
          hits_d     = '0;
          cycles_d   = '0;
          err_d      = E_NONE;
          bad_adr_d  = '0;
          bad_data_d = '0;
        end
      end
    endcase

    busy_d = (state_d == S_RUN);
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      hits_q     <= '0;
      cycles_q   <= '0;
      err_q      <= E_NONE;
      bad_adr_q  <= '0;
      bad_data_q <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_CHECKS); i++) begin
        tab_addr_q[i] <= '0;
        tab_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hits_q     <= hits_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
      bad_adr_q  <= bad_adr_d;
      bad_data_q <= bad_data_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tab_addr_q <= tab_addr_d;
      tab_data_q <= tab_data_d;
    end
  end

  assign busy     = busy_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_code = err_q;
  assign hits     = hits_q;
  assign cycles   = cycles_q;
  assign bad_adr  = bad_adr_q;
  assign bad_data = bad_data_q;

endmodule
